decode_stage: RTL
=================

Name: decode_stage

Overview:
- Instruction decode stage and IF/ID-to-ID/EX pipeline boundary, directly downstream of the fetch stage.
- Consumes the fetched instruction word plus its PC and PC+2, then decodes fields, control bits and the sign-extended immediate.
- Detects load-use hazards, stalls fetch and inserts bubbles.
- Honours flushes from execute when a branch or jump is taken.

Parameters:
- STALL_CNT_W, 8, width of the saturating stall-cycle performance counter.

Ports:
- clk  input  1  stage clock, rising-edge
- reset  input  1  asynchronous, active-high
- ir  input  16  instruction word from fetch
- old_pc  input  16  PC of ir
- old_pcp2  input  16  PC+2 of ir
- if_valid  input  1  ir/old_pc/old_pcp2 are a real instruction
- flush  input  1  taken branch/jump in EX; kill the instruction in this stage
- ex_mem_read  input  1  instruction currently in EX is LW
- ex_rd  input  4  destination of the instruction in EX
- stall  output  1  combinational; fetch must hold its PC this cycle
- id_valid  output  1  registered; ID/EX slot holds a real instruction
- id_pc, id_pcp2  output  16 each  registered PC and PC+2
- id_rs1, id_rs2, id_rd  output  4 each  registered register specifiers
- id_imm  output  16  registered immediate
- id_alu_op  output  3  0 add, 1 sub, 2 and, 3 or, 4 pass-imm
- id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_branch_eq, id_branch_ne, id_jump  output  1 each  registered control bits
- id_illegal  output  1  registered; illegal opcode seen
- stall_count  output  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Reset is asynchronous, active-high. It clears every registered output and stall_count to 0 and puts the FSM in RUN.
- Instruction layout:
  - opcode = ir[3:0]; rd = ir[7:4]; rs1 = ir[11:8]; rs2 = ir[15:12].
  - imm4 = ir[15:12]; offs = ir[7:4]; imm8 = ir[15:8].
- Opcode decode:
  - 0-3 ADD/SUB/AND/OR (R-type): alu_op = opcode, reg_write.
  - 4 ADDI: imm = sext(imm4), alu_src_imm, add, reg_write; rs2 field forced to 0.
  - 5 LW: same as ADDI plus mem_read.
  - 6 SW: imm = sext(offs), alu_src_imm, add, mem_write, rd output 0.
  - 7 BEQ / 8 BNE: imm = sext(offs)<<1, sub, branch_eq / branch_ne, rd output 0.
  - 9 JAL: imm = sext(imm8)<<1, jump, reg_write; rs1 = rs2 = 0.
  - A LUI: imm = {imm8, 8'h00}, pass-imm, reg_write.
  - B-F: illegal. The slot is emitted with id_illegal=1, id_valid=1 and all other control bits 0.
- r0 rule: reg_write is forced to 0 when rd == 0.
- Operand usage:
  - rs1 is "used" for all opcodes except JAL and LUI.
  - rs2 is "used" for R-type, SW, BEQ and BNE.
- Hazard condition: ex_mem_read && ex_rd != 0 && (ex_rd == used rs1 || ex_rd == used rs2), evaluated on the current source instruction.
- Source instruction: the live ir/old_pc/old_pcp2/if_valid in RUN; the internal hold register in HOLD.
- FSM state RUN:
  - If if_valid, no hazard and no flush: the decoded instruction is registered into ID/EX at the next edge (1-cycle latency).
  - If the hazard is true and no flush: stall=1. The source is captured into the hold register, a bubble is registered (id_valid=0, all control bits 0) and the FSM goes to HOLD.
- FSM state HOLD:
  - The source is the hold register, because the synchronous instruction memory has already advanced.
  - If the hazard is still true: stall=1, another bubble, stay in HOLD.
  - Otherwise: the held instruction is registered, stall=0, return to RUN.
- Bubbles: if_valid=0 in RUN registers a bubble.
- Flush has priority over the hazard in both states:
  - ID/EX becomes a bubble and stall=0.
  - The hold register is invalidated and the FSM returns to RUN.
- stall_count: increments each cycle stall=1 and saturates at all-ones.
- Bubble contents: id_pc/id_pcp2/specifiers/immediate are don't-care, but are driven 0 for determinism.
- Reset asserted mid-HOLD discards the held instruction immediately.

Test Plan:
- Reset, then ADDI r2,r0,-1 (ir=16'hF024, old_pc=0x0010) -> next edge: id_valid=1, id_rd=2, id_imm=0xFFFF, id_reg_write=1, id_alu_src_imm=1, id_pcp2=0x0012.
- LUI r3,0xAB (ir=16'hAB3A) -> id_imm=0xAB00, id_alu_op=4; ADD r0,r1,r2 (ir=16'h2100) -> id_reg_write=0.
- ex_mem_read=1, ex_rd=1 while ir=ADD r4,r1,r2 (16'h2140); ir changes to 16'h0000 next cycle -> stall=1 for 1 cycle, one bubble, then ADD r4 emitted with id_rs1=1; stall_count=1.
- Same hazard held 3 cycles -> 3 bubbles then ADD emitted; stall_count=3. Repeat 300 stall cycles -> stall_count=255.
- Flush asserted during HOLD -> bubble, stall=0, FSM in RUN, held ADD never appears on id_valid.
- ir=16'h000C -> id_illegal=1, id_valid=1, all other control 0; asynchronous reset mid-cycle -> all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: instruction decode plus the IF/ID -> ID/EX register.
// Decodes the 16-bit instruction word into fields, control bits and an
// immediate. A load-use hazard against the LW in EX stalls fetch and
// inserts bubbles. A taken branch/jump (flush) kills the slot.
module decode_stage #(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            ir,
  input  logic [15:0]            old_pc,
  input  logic [15:0]            old_pcp2,
  input  logic                   if_valid,
  input  logic                   flush,
  input  logic                   ex_mem_read,
  input  logic [3:0]             ex_rd,
  output logic                   stall,
  output logic                   id_valid,
  output logic [15:0]            id_pc,
  output logic [15:0]            id_pcp2,
  output logic [3:0]             id_rs1,
  output logic [3:0]             id_rs2,
  output logic [3:0]             id_rd,
  output logic [15:0]            id_imm,
  output logic [2:0]             id_alu_op,
  output logic                   id_alu_src_imm,
  output logic                   id_reg_write,
  output logic                   id_mem_read,
  output logic                   id_mem_write,
  output logic                   id_branch_eq,
  output logic                   id_branch_ne,
  output logic                   id_jump,
  output logic                   id_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef enum logic {S_RUN, S_HOLD} state_t;

  state_t r_state, w_next;

  // Hold register: fetch has already moved on by the time a stall is seen,
  // so the stalled instruction must be kept here.
  logic        r_hold_valid;
  logic [15:0] r_hold_ir, r_hold_pc, r_hold_pcp2;

  logic        w_src_valid;
  logic [15:0] w_src_ir, w_src_pc, w_src_pcp2;

  logic [3:0]  w_op, w_rs1, w_rs2, w_rd;
  logic [15:0] w_imm;
  logic [2:0]  w_alu_op;
  logic        w_src_imm, w_rw, w_mr, w_mw, w_beq, w_bne, w_jmp, w_ill;
  logic        w_use1, w_use2, w_haz, w_capture, w_emit;

  // Source instruction: live fetch output in RUN, held copy in HOLD.
  always_comb begin
    if (r_state == S_HOLD) begin
      w_src_valid = r_hold_valid;
      w_src_ir    = r_hold_ir;
      w_src_pc    = r_hold_pc;
      w_src_pcp2  = r_hold_pcp2;
    end else begin
      w_src_valid = if_valid;
      w_src_ir    = ir;
      w_src_pc    = old_pc;
      w_src_pcp2  = old_pcp2;
    end
  end

  assign w_op = w_src_ir[3:0];

  // Field/control decode of the source instruction.
  always_comb begin
    w_rd      = w_src_ir[7:4];
    w_rs1     = w_src_ir[11:8];
    w_rs2     = w_src_ir[15:12];
    w_imm     = 16'h0000;
    w_alu_op  = 3'd0;
    w_src_imm = 1'b0;
    w_rw      = 1'b0;
    w_mr      = 1'b0;
    w_mw      = 1'b0;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    w_jmp     = 1'b0;
    w_ill     = 1'b0;
    w_use1    = 1'b1;
    w_use2    = 1'b0;
    case (w_op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        w_alu_op = w_op[2:0];
        w_rw     = 1'b1;
        w_use2   = 1'b1;
      end
      4'h4, 4'h5: begin
        w_imm     = {{12{w_src_ir[15]}}, w_src_ir[15:12]};
        w_src_imm = 1'b1;
        w_rw      = 1'b1;
        w_mr      = (w_op == 4'h5);
        w_rs2     = 4'h0;
      end
      4'h6: begin
        w_imm     = {{12{w_src_ir[7]}}, w_src_ir[7:4]};
        w_src_imm = 1'b1;
        w_mw      = 1'b1;
        w_rd      = 4'h0;
        w_use2    = 1'b1;
      end
      4'h7, 4'h8: begin
        w_imm    = {{11{w_src_ir[7]}}, w_src_ir[7:4], 1'b0};
        w_alu_op = 3'd1;
        w_beq    = (w_op == 4'h7);
        w_bne    = (w_op == 4'h8);
        w_rd     = 4'h0;
        w_use2   = 1'b1;
      end
      4'h9: begin
        w_imm  = {{7{w_src_ir[15]}}, w_src_ir[15:8], 1'b0};
        w_jmp  = 1'b1;
        w_rw   = 1'b1;
        w_rs1  = 4'h0;
        w_rs2  = 4'h0;
        w_use1 = 1'b0;
      end
      4'hA: begin
        w_imm    = {w_src_ir[15:8], 8'h00};
        w_alu_op = 3'd4;
        w_rw     = 1'b1;
        w_use1   = 1'b0;
      end
      default: w_ill = 1'b1;
    endcase
    // r0 is hard-wired zero: never write it.
    if (w_rd == 4'h0) w_rw = 1'b0;
  end

  // Load-use hazard; an empty slot never stalls.
  assign w_haz = w_src_valid && ex_mem_read && (ex_rd != 4'h0) &&
                 ((w_use1 && (ex_rd == w_rs1)) || (w_use2 && (ex_rd == w_rs2)));

  // Next state and stall/emit decisions; flush outranks the hazard.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    w_capture = 1'b0;
    w_emit    = 1'b0;
    if (flush) begin
      w_next = S_RUN;
    end else if (w_haz) begin
      stall     = 1'b1;
      w_next    = S_HOLD;
      w_capture = (r_state == S_RUN);
    end else begin
      w_emit = w_src_valid;
      w_next = S_RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_next;
  end

  // Hold register: load on entering HOLD, drop on returning to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_ir    <= 16'h0000;
      r_hold_pc    <= 16'h0000;
      r_hold_pcp2  <= 16'h0000;
    end else if (w_capture) begin
      r_hold_valid <= w_src_valid;
      r_hold_ir    <= w_src_ir;
      r_hold_pc    <= w_src_pc;
      r_hold_pcp2  <= w_src_pcp2;
    end else if (w_next == S_RUN) begin
      r_hold_valid <= 1'b0;
    end
  end

  // ID/EX register: decoded instruction or an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || !w_emit) begin
      id_valid       <= 1'b0;
      id_pc          <= 16'h0000;
      id_pcp2        <= 16'h0000;
      id_rs1         <= 4'h0;
      id_rs2         <= 4'h0;
      id_rd          <= 4'h0;
      id_imm         <= 16'h0000;
      id_alu_op      <= 3'd0;
      id_alu_src_imm <= 1'b0;
      id_reg_write   <= 1'b0;
      id_mem_read    <= 1'b0;
      id_mem_write   <= 1'b0;
      id_branch_eq   <= 1'b0;
      id_branch_ne   <= 1'b0;
      id_jump        <= 1'b0;
      id_illegal     <= 1'b0;
    end else begin
      id_valid       <= 1'b1;
      id_pc          <= w_src_pc;
      id_pcp2        <= w_src_pcp2;
      id_rs1         <= w_rs1;
      id_rs2         <= w_rs2;
      id_rd          <= w_rd;
      id_imm         <= w_imm;
      id_alu_op      <= w_alu_op;
      id_alu_src_imm <= w_src_imm;
      id_reg_write   <= w_rw;
      id_mem_read    <= w_mr;
      id_mem_write   <= w_mw;
      id_branch_eq   <= w_beq;
      id_branch_ne   <= w_bne;
      id_jump        <= w_jmp;
      id_illegal     <= w_ill;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end

endmodule
